// File: rtl/fetch_unit_pkg.sv
// Shared pipeline types for the fetch stage and its hazard-control neighbours.
package fetch_unit_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned PIPE_REQ_W = 2;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } FetchInfo;

    typedef struct packed {
        logic [PIPE_REQ_W-1:0] stall_req;
        logic [PIPE_REQ_W-1:0] flush_req;
    } PipeRequest;

    typedef struct packed {
        logic stall;
        logic flush;
    } PipeControl;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read, redirect/flush handling and a
// single-entry hold buffer for responses that arrive while decode is stalled.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output PipeRequest      req,
    input  PipeControl      pipe,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output FetchInfo        fetch_info,
    output logic            error
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] req_pc, req_pc_n;
    FetchInfo        hold, hold_n;
    FetchInfo        info_n;
    logic            kill;

    // Fetch never asks the pipeline to stall or flush.
    assign req = '0;

    // Next-state, next-pc and decode-stage payload.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        req_pc_n = req_pc;
        hold_n   = hold;
        info_n   = fetch_info;
        kill     = redirect_valid | pipe.flush;

        if (!pipe.stall) begin
            info_n.valid = 1'b0;
        end
        if (redirect_valid) begin
            pc_n = word_align(redirect_pc);
        end

        case (state)
            FS_REQ: begin
                if (kill) begin
                    // An accepted-but-abandoned request still owes a response.
                    state_n = imem_req_ready ? FS_DROP : FS_REQ;
                end else if (imem_req_ready) begin
                    req_pc_n = pc;
                    pc_n     = pc + XLEN'(4);
                    state_n  = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (kill) begin
                    state_n = imem_resp_valid ? FS_REQ : FS_DROP;
                end else if (imem_resp_valid) begin
                    if (pipe.stall) begin
                        hold_n  = '{valid: 1'b1, pc: req_pc, inst: imem_resp_data};
                        state_n = FS_HOLD;
                    end else begin
                        info_n  = '{valid: 1'b1, pc: req_pc, inst: imem_resp_data};
                        state_n = FS_REQ;
                    end
                end
            end
            FS_HOLD: begin
                if (kill) begin
                    state_n = FS_REQ;
                end else if (!pipe.stall) begin
                    info_n  = hold;
                    state_n = FS_REQ;
                end
            end
            FS_DROP: begin
                if (imem_resp_valid) begin
                    state_n = FS_REQ;
                end
            end
            default: state_n = FS_REQ;
        endcase

        if (kill) begin
            info_n.valid = 1'b0;
            hold_n       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= FS_REQ;
            pc             <= RESET_PC;
            req_pc         <= '0;
            hold           <= '0;
            fetch_info     <= '0;
            error          <= 1'b0;
            imem_req_valid <= 1'b1;
            imem_req_addr  <= RESET_PC;
        end else begin
            state          <= state_n;
            pc             <= pc_n;
            req_pc         <= req_pc_n;
            hold           <= hold_n;
            fetch_info     <= info_n;
            error          <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            imem_req_valid <= (state_n == FS_REQ);
            imem_req_addr  <= pc_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: memory/pipeline model feeds a scoreboard
// that a separate monitor drains against fetch_info.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    PipeRequest  req;
    PipeControl  pipe = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    FetchInfo    fetch_info;
    logic        error;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .pipe           (pipe),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .fetch_info     (fetch_info),
        .error          (error)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Stimulus knobs (percentages and memory latency range).
    int unsigned p_ready = 100, p_stall = 0, p_redir = 0, p_flush = 0;
    int unsigned min_lat = 0, max_lat = 0;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_data = '0;
    bit          ov_redir = 1'b0;
    logic [31:0] ov_pc = '0;

    // Reference model: memory with one owed response, plus the in-flight fetch.
    bit          mem_busy = 1'b0, txn_live = 1'b0, txn_got = 1'b0;
    int unsigned mem_lat = 0;
    logic [31:0] mem_data = '0, txn_pc = '0, txn_inst = '0;
    logic [31:0] exp_pc = RESET_PC;
    logic        exp_err = 1'b0;
    bit          stab_armed = 1'b0;
    logic [31:0] stab_addr = '0;
    bit          done = 1'b0;

    logic        rst_q = 1'b1, stall_q = 1'b0, kill_q = 1'b0;
    FetchInfo    last = '0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_q   <= rst;
        stall_q <= pipe.stall;
        kill_q  <= redirect_valid | pipe.flush;
    end

    task automatic chk(input bit ok, input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: protocol checks and scoreboard drain, once per cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            chk(sb.size() == 0, "sb_drained", 65'(sb.size()), 65'd0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end else if (rst_q) begin
            sb.delete();
            chk(imem_req_valid == 1'b1, "rst_req_valid", 65'(imem_req_valid), 65'd1);
            chk(imem_req_addr == RESET_PC, "rst_req_addr", 65'(imem_req_addr), 65'(RESET_PC));
            chk(fetch_info == '0, "rst_fetch_info", 65'(fetch_info), 65'd0);
            chk(error == 1'b0, "rst_error", 65'(error), 65'd0);
        end else begin
            chk(req == '0, "pipe_req", 65'(req), 65'd0);
            chk(error == exp_err, "error", 65'(error), 65'(exp_err));
            if (mem_busy || txn_got) begin
                chk(!imem_req_valid, "req_while_busy", 65'(imem_req_valid), 65'd0);
            end else begin
                chk(imem_req_valid, "req_idle", 65'(imem_req_valid), 65'd1);
                chk(imem_req_addr == exp_pc, "req_addr", 65'(imem_req_addr), 65'(exp_pc));
            end
            if (stab_armed) begin
                chk(imem_req_valid && imem_req_addr == stab_addr, "req_stable",
                    65'({imem_req_valid, imem_req_addr}), 65'({1'b1, stab_addr}));
            end
            while (sb.size() != 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk(1'b0, "fetch_missing", 65'(fetch_info), 65'({1'b1, e.pc, e.inst}));
            end
            if (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk(fetch_info.valid && fetch_info.pc == e.pc && fetch_info.inst == e.inst,
                    "fetch_data", 65'(fetch_info), 65'({1'b1, e.pc, e.inst}));
            end else if (stall_q && !kill_q) begin
                chk(fetch_info.valid == last.valid &&
                    (!last.valid || (fetch_info.pc == last.pc && fetch_info.inst == last.inst)),
                    "fetch_hold", 65'(fetch_info), 65'(last));
            end else begin
                chk(!fetch_info.valid, "fetch_bubble", 65'(fetch_info.valid), 65'd0);
            end
        end
        last = fetch_info;
    end

    task automatic model_reset();
        mem_busy   = 1'b0;
        txn_live   = 1'b0;
        txn_got    = 1'b0;
        exp_pc     = RESET_PC;
        exp_err    = 1'b0;
        stab_armed = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        pipe           = '0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic knobs(input int unsigned r, input int unsigned s, input int unsigned rd,
                         input int unsigned fl, input int unsigned mn, input int unsigned mx);
        p_ready = r; p_stall = s; p_redir = rd; p_flush = fl; min_lat = mn; max_lat = mx;
    endtask

    // Drive one cycle of stimulus and advance the model across the next edge.
    task automatic cycle();
        logic        kill, resp_now, accept;
        logic [31:0] rp;
        rp = $urandom;
        if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
        redirect_valid = ov_redir || ($urandom_range(0, 99) < p_redir);
        if (ov_redir) rp = ov_pc;
        ov_redir        = 1'b0;
        redirect_pc     = rp;
        pipe.flush      = ($urandom_range(0, 99) < p_flush);
        pipe.stall      = ($urandom_range(0, 99) < p_stall);
        imem_req_ready  = ($urandom_range(0, 99) < p_ready);
        resp_now        = mem_busy && (mem_lat == 0);
        imem_resp_valid = resp_now;
        imem_resp_data  = resp_now ? mem_data : $urandom;
        if (mem_busy && !resp_now) mem_lat--;

        kill = redirect_valid || pipe.flush;
        if (kill) begin
            txn_live = 1'b0;
            txn_got  = 1'b0;
        end
        if (resp_now) begin
            mem_busy = 1'b0;
            if (txn_live) begin
                txn_got  = 1'b1;
                txn_inst = mem_data;
            end
        end
        if (txn_got && !pipe.stall) begin
            sb.push_back('{due: cyc + 1, pc: txn_pc, inst: txn_inst});
            txn_live = 1'b0;
            txn_got  = 1'b0;
        end
        accept = imem_req_valid && imem_req_ready;
        if (accept) begin
            mem_busy = 1'b1;
            mem_lat  = $urandom_range(max_lat, min_lat);
            mem_data = fixed_en ? fixed_data : $urandom;
            txn_live = !kill;
            txn_pc   = exp_pc;
        end
        exp_err = redirect_valid && (rp[1:0] != 2'b00);
        if (redirect_valid) exp_pc = {rp[31:2], 2'b00};
        else if (accept && !pipe.flush) exp_pc = exp_pc + 32'd4;
        stab_armed = imem_req_valid && !accept && !kill;
        stab_addr  = imem_req_addr;
        @(negedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        #1;
        do_reset(3);

        // Single-cycle memory returning a NOP.
        fixed_en = 1'b1; fixed_data = 32'h0000_0013;
        knobs(100, 0, 0, 0, 0, 0);
        repeat (10) cycle();

        // Response arrives under a 3-cycle stall.
        fixed_data = 32'hDEAD_BEEF;
        knobs(100, 0, 0, 0, 1, 1);
        for (int i = 0; i < 10 && !mem_busy; i++) cycle();
        p_stall = 100;
        repeat (3) cycle();
        p_stall = 0;
        repeat (4) cycle();

        // Redirect while waiting on a late response.
        fixed_en = 1'b0;
        knobs(100, 0, 0, 0, 2, 2);
        for (int i = 0; i < 10 && !mem_busy; i++) cycle();
        ov_redir = 1'b1; ov_pc = 32'h0000_0100;
        repeat (8) cycle();

        // Misaligned redirect, then memory refusing requests.
        knobs(100, 0, 0, 0, 0, 0);
        ov_redir = 1'b1; ov_pc = 32'h0000_0203;
        repeat (5) cycle();
        p_ready = 0;
        repeat (4) cycle();
        p_ready = 100;
        repeat (4) cycle();

        // Wrap from the top of the address space.
        ov_redir = 1'b1; ov_pc = 32'hFFFF_FFFC;
        repeat (6) cycle();

        // Mixed random traffic, a mid-transaction reset, then heavier stalls.
        knobs(70, 25, 5, 4, 0, 3);
        repeat (600) cycle();
        do_reset(2);
        knobs(100, 0, 0, 0, 0, 0);
        repeat (6) cycle();
        knobs(60, 60, 4, 3, 0, 3);
        repeat (300) cycle();

        knobs(100, 0, 0, 0, 0, 0);
        repeat (12) cycle();
        done = 1'b1;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  output  PipeRequest  pipeline request; stall_req and flush_req (4'b0000) tied to 0.
REQ-005 pipe  input  PipeControl  global stall/flush from hazard control.
REQ-006 redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-007 redirect_pc  input  32  new fetch address.
REQ-008 imem_req_valid  output  1  instruction-memory read request.
REQ-009 imem_req_addr  output  32  word address of request.
REQ-010 imem_req_ready  input  1  memory accepts request this cycle.
REQ-011 imem_resp_valid  input  1  read data valid; at most one per accepted request, in order.
REQ-012 imem_resp_data  input  32  instruction word.
REQ-013 fetch_info  output  FetchInfo  registered {valid, pc[31:0], inst[31:0]} to the decode stage.
REQ-014 error  output  1  one-cycle pulse: misaligned redirect_pc.

Function
REQ-015 FSM states: REQ (drive request), WAIT (one request outstanding), DROP (discard in-flight response), HOLD (response buffered during stall).
REQ-016 At most one outstanding imem request at any time.
REQ-017 REQ: imem_req_valid=1, imem_req_addr=pc; on valid&ready, req_pc<=pc, pc<=pc+4 (mod 2^32 wrap), go WAIT.
REQ-018 Once asserted, imem_req_valid and imem_req_addr stay stable until accepted; redirect_valid or pipe.flush are the only exceptions.
REQ-019 WAIT on imem_resp_valid: if !pipe.stall, fetch_info<={1,req_pc,imem_resp_data}, go REQ; if pipe.stall, capture into hold register, go HOLD.
REQ-020 HOLD: no request issued; on first cycle with !pipe.stall, fetch_info<=hold contents, go REQ.
REQ-021 pipe.stall without new data: fetch_info held unchanged.
REQ-022 No stall and no new data delivered: fetch_info.valid<=0 (bubble); pc and inst fields don't-care.
REQ-023 redirect_valid: pc<=redirect_pc with bits[1:0] forced 00; fetch_info.valid<=0; hold register cleared.
REQ-024 pipe.flush: fetch_info.valid<=0; hold register cleared; pc unchanged unless redirect_valid is also set.
REQ-025 Redirect/flush in WAIT without same-cycle response, or in HOLD: go DROP if a response is still owed, else REQ.
REQ-026 Redirect/flush in WAIT with same-cycle imem_resp_valid: response discarded, go REQ.
REQ-027 Redirect/flush in REQ: pending request abandoned; REQ restarts next cycle with the new pc.
REQ-028 DROP: next imem_resp_valid discarded, go REQ; a redirect while in DROP updates pc and stays in DROP.
REQ-029 Priority: rst > redirect_valid/pipe.flush > pipe.stall > normal flow.
REQ-030 error=1 for one cycle when redirect_valid and redirect_pc[1:0]!=0, else 0.
REQ-031 Latency: response accepted in cycle N gives fetch_info valid in N+1; with single-cycle memory, steady-state throughput is one instruction per 2 cycles.

Reset
REQ-032 On rst: state=REQ, pc=RESET_PC, req_pc=0, fetch_info=0, hold register=0, error=0.
REQ-033 Reset mid-transaction abandons any outstanding request; the memory model is reset in the same cycle.
REQ-034 imem_req_valid=1 with addr RESET_PC in the first cycle after rst deasserts.

Structure
REQ-035 FetchInfo, PipeRequest and PipeControl live in the shared common package; fetch_state_t enum is defined there too.
REQ-036 Single module, no sub-module; hold register and FSM are inline.

Verification
REQ-037 Reset, 1-cycle memory returning 32'h00000013 for every address -> requests at 0x0,0x4,0x8; fetch_info.pc 0x0,0x4,0x8 valid every 2nd cycle.
REQ-038 pipe.stall for 3 cycles while response 32'hDEADBEEF arrives -> fetch_info unchanged through the stall, then {1,req_pc,DEADBEEF}; no request issued during HOLD.
REQ-039 redirect_pc=0x100 while WAIT with response 2 cycles late -> late response dropped, fetch_info.valid=0, next request addr 0x100.
REQ-040 redirect_pc=0x203 -> error pulse 1 cycle, next request addr 0x200.
REQ-041 imem_req_ready low 4 cycles -> imem_req_valid and addr 0x8 held stable all 4 cycles.
REQ-042 pc=0xFFFFFFFC accepted -> next request addr 0x00000000.
